// File: rtl/bus_read_arbiter.sv
// bus_read_arbiter: two-master, single-slave read arbiter with exactly one
// read outstanding at a time.
//   Master 1 is instruction fetch and master 2 is data access. The slave is a
//   memory with separate read-address and read-data handshakes.
//   Simultaneous requests are resolved as follows:
//     - ARB_ROUND_ROBIN_EN defined: the master that was not served last wins.
//     - ARB_ROUND_ROBIN_EN undefined (default): master 2 always wins.
//   Address, owner, busy and s_raddr_valid are registered. The read-data path
//   is a combinational pass-through between the slave and the owning master.
module bus_read_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // master 1 (instruction fetch)
  input  logic              m1_raddr_valid,
  output logic              m1_raddr_ready,
  input  logic [ADDR_W-1:0] m1_raddr,
  output logic              m1_rdata_valid,
  input  logic              m1_rdata_ready,
  output logic [DATA_W-1:0] m1_rdata,
  // master 2 (data access)
  input  logic              m2_raddr_valid,
  output logic              m2_raddr_ready,
  input  logic [ADDR_W-1:0] m2_raddr,
  output logic              m2_rdata_valid,
  input  logic              m2_rdata_ready,
  output logic [DATA_W-1:0] m2_rdata,
  // slave (memory)
  output logic              s_raddr_valid,
  input  logic              s_raddr_ready,
  output logic [ADDR_W-1:0] s_raddr,
  input  logic              s_rdata_valid,
  output logic              s_rdata_ready,
  input  logic [DATA_W-1:0] s_rdata,
  // status
  output logic              busy,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_reg;
  logic [1:0]        owner_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              busy_reg;
  logic              s_raddr_valid_reg;

  // Per-master views, bit 0 = m1, bit 1 = m2.
  logic [1:0]        req_vec;
  logic [1:0]        rdata_ready_vec;
  logic [1:0]        rdata_valid_vec;
  logic [1:0]        owner_ready_vec;
  logic [1:0]        grant_next;
  logic [ADDR_W-1:0] addr_next;
  logic              in_idle;
  logic              in_data;

  assign req_vec         = {m2_raddr_valid, m1_raddr_valid};
  assign rdata_ready_vec = {m2_rdata_ready, m1_rdata_ready};
  assign in_idle         = (state_reg == IDLE);
  assign in_data         = (state_reg == DATA);

`ifdef ARB_ROUND_ROBIN_EN
  // Set when master 2 was the last one served. Reset value makes master 1
  // the first winner of a tie.
  logic last_m2_reg;

  // Round-robin arbitration: on a tie, grant the master not served last.
  always_comb begin
    grant_next = 2'b00;
    if (req_vec == 2'b11) begin
      grant_next = last_m2_reg ? 2'b01 : 2'b10;
    end else begin
      grant_next = req_vec;
    end
  end
`else
  // Fixed-priority arbitration: data access (m2) always beats instruction fetch.
  always_comb begin
    grant_next = 2'b00;
    if (req_vec[1]) begin
      grant_next = 2'b10;
    end else if (req_vec[0]) begin
      grant_next = 2'b01;
    end
  end
`endif

  assign addr_next = grant_next[1] ? m2_raddr : m1_raddr;

  // The address-accept ready is combinational so the winner sees it in the
  // same cycle. It is gated by reset so nothing is accepted while rst is low.
  assign m1_raddr_ready = in_idle & rst & grant_next[0];
  assign m2_raddr_ready = in_idle & rst & grant_next[1];

  // Read-data path: each master's valid is the slave's valid qualified by
  // ownership. The slave's ready follows the owning master only.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      assign rdata_valid_vec[gi] = in_data & owner_reg[gi] & s_rdata_valid;
      assign owner_ready_vec[gi] = owner_reg[gi] & rdata_ready_vec[gi];
    end
  endgenerate

  assign m1_rdata_valid = rdata_valid_vec[0];
  assign m2_rdata_valid = rdata_valid_vec[1];
  assign s_rdata_ready  = in_data & (|owner_ready_vec);

  // Both masters see the slave data; only rdata_valid gives it meaning.
  assign m1_rdata = s_rdata;
  assign m2_rdata = s_rdata;

  assign s_raddr_valid = s_raddr_valid_reg;
  assign s_raddr       = addr_reg;
  assign busy          = busy_reg;
  assign owner         = owner_reg;

  // Transaction FSM: IDLE accepts one request, ADDR presents it to the slave,
  // and DATA returns the response to the owner. All outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      owner_reg         <= 2'b00;
      addr_reg          <= '0;
      busy_reg          <= 1'b0;
      s_raddr_valid_reg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_m2_reg       <= 1'b1;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_next != 2'b00) begin
            state_reg         <= ADDR;
            owner_reg         <= grant_next;
            addr_reg          <= addr_next;
            busy_reg          <= 1'b1;
            s_raddr_valid_reg <= 1'b1;
          end
        end
        ADDR: begin
          if (s_raddr_ready) begin
            state_reg         <= DATA;
            s_raddr_valid_reg <= 1'b0;
          end
        end
        DATA: begin
          if (s_rdata_valid && s_rdata_ready) begin
            state_reg   <= IDLE;
            owner_reg   <= 2'b00;
            busy_reg    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_m2_reg <= owner_reg[1];
`endif
          end
        end
        default: begin
          state_reg         <= IDLE;
          owner_reg         <= 2'b00;
          busy_reg          <= 1'b0;
          s_raddr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_read_arbiter.sv
// tb_bus_read_arbiter: directed bench for bus_read_arbiter. It uses a
// scoreboard of expected (owner, data) responses, pushed when a request is
// granted and popped on the master-side read-data handshake.
module tb_bus_read_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m1_raddr_valid, m1_raddr_ready, m1_rdata_valid, m1_rdata_ready;
  logic [AW-1:0] m1_raddr;
  logic [DW-1:0] m1_rdata;
  logic          m2_raddr_valid, m2_raddr_ready, m2_rdata_valid, m2_rdata_ready;
  logic [AW-1:0] m2_raddr;
  logic [DW-1:0] m2_rdata;
  logic          s_raddr_valid, s_raddr_ready, s_rdata_valid, s_rdata_ready;
  logic [AW-1:0] s_raddr;
  logic [DW-1:0] s_rdata;
  logic          busy;
  logic [1:0]    owner;

  typedef struct packed {
    logic [1:0]    who;
    logic [DW-1:0] data;
  } sb_t;

  sb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  bus_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m1_raddr_valid(m1_raddr_valid), .m1_raddr_ready(m1_raddr_ready), .m1_raddr(m1_raddr),
    .m1_rdata_valid(m1_rdata_valid), .m1_rdata_ready(m1_rdata_ready), .m1_rdata(m1_rdata),
    .m2_raddr_valid(m2_raddr_valid), .m2_raddr_ready(m2_raddr_ready), .m2_raddr(m2_raddr),
    .m2_rdata_valid(m2_rdata_valid), .m2_rdata_ready(m2_rdata_ready), .m2_rdata(m2_rdata),
    .s_raddr_valid(s_raddr_valid), .s_raddr_ready(s_raddr_ready), .s_raddr(s_raddr),
    .s_rdata_valid(s_rdata_valid), .s_rdata_ready(s_rdata_ready), .s_rdata(s_rdata),
    .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check that every output is at its reset/idle value.
  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_s_raddr"}, s_raddr, 0);
    chk({tag, "_s_raddr_valid"}, s_raddr_valid, 0);
    chk({tag, "_s_rdata_ready"}, s_rdata_ready, 0);
    chk({tag, "_raddr_ready"}, {m2_raddr_ready, m1_raddr_ready}, 0);
    chk({tag, "_rdata_valid"}, {m2_rdata_valid, m1_rdata_valid}, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One full read. req: requesting masters; gnt: expected one-hot winner.
  // aw: cycles of s_raddr_ready low; dw: cycles of s_rdata_valid low;
  // rw: cycles the owner holds rdata_ready low with data valid.
  task automatic run_txn(input logic [1:0] req, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [1:0] gnt,
                         input logic [DW-1:0] data, input int aw, input int dw,
                         input int rw);
    logic [AW-1:0] ea;
    logic [1:0]    got;
    logic [DW-1:0] gd;
    logic          ordy;
    sb_t           e;
    ea = gnt[1] ? a2 : a1;
    m1_raddr_valid = req[0]; m1_raddr = a1;
    m2_raddr_valid = req[1]; m2_raddr = a2;
    s_raddr_ready = 1'b0; s_rdata_valid = 1'b0;
    m1_rdata_ready = 1'b1; m2_rdata_ready = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_owner", owner, 0);
    chk("idle_s_raddr_valid", s_raddr_valid, 0);
    chk("grant", {m2_raddr_ready, m1_raddr_ready}, gnt);
    e.who = gnt; e.data = data;
    exp_q.push_back(e);
    @(posedge clk); #1;
    // The winner drops its request and scrambles its address bus; the loser
    // keeps requesting.
    if (gnt[0]) begin m1_raddr_valid = 1'b0; m1_raddr = ~a1; end
    if (gnt[1]) begin m2_raddr_valid = 1'b0; m2_raddr = ~a2; end
    for (int i = 0; i <= aw; i++) begin
      s_raddr_ready = (i == aw);
      @(negedge clk);
      chk("addr_s_raddr_valid", s_raddr_valid, 1);
      chk("addr_s_raddr", s_raddr, ea);
      chk("addr_busy", busy, 1);
      chk("addr_owner", owner, gnt);
      chk("addr_raddr_ready", {m2_raddr_ready, m1_raddr_ready}, 0);
      chk("addr_rdata_valid", {m2_rdata_valid, m1_rdata_valid}, 0);
      @(posedge clk); #1;
    end
    s_raddr_ready = 1'b0;
    s_rdata = data;
    for (int i = 0; i <= dw + rw; i++) begin
      s_rdata_valid = (i >= dw);
      ordy = (i < dw) || (i == dw + rw);
      if (gnt[0]) m1_rdata_ready = ordy; else m2_rdata_ready = ordy;
      @(negedge clk);
      chk("data_busy", busy, 1);
      chk("data_owner", owner, gnt);
      chk("data_s_raddr", s_raddr, ea);
      chk("data_s_raddr_valid", s_raddr_valid, 0);
      chk("data_raddr_ready", {m2_raddr_ready, m1_raddr_ready}, 0);
      chk("data_rdata_valid", {m2_rdata_valid, m1_rdata_valid}, (i >= dw) ? gnt : 2'b00);
      chk("data_s_rdata_ready", s_rdata_ready, ordy);
      if (i == dw + rw) begin
        got = {m2_rdata_valid & m2_rdata_ready, m1_rdata_valid & m1_rdata_ready};
        gd  = got[1] ? m2_rdata : m1_rdata;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_who", got, e.who);
          chk("sb_data", gd, e.data);
        end
      end
      @(posedge clk); #1;
    end
    s_rdata_valid = 1'b0;
    m1_raddr_valid = 1'b0; m2_raddr_valid = 1'b0;
    m1_rdata_ready = 1'b1; m2_rdata_ready = 1'b1;
    $display("txn req=%b grant=%b addr=%h data=%h aw=%0d dw=%0d rw=%0d",
             req, gnt, ea, data, aw, dw, rw);
  endtask

  initial begin
    logic [1:0] tie_g [3];
`ifdef ARB_ROUND_ROBIN_EN
    tie_g[0] = 2'b01; tie_g[1] = 2'b10; tie_g[2] = 2'b01;
`else
    tie_g[0] = 2'b10; tie_g[1] = 2'b10; tie_g[2] = 2'b10;
`endif
    rst = 1'b0;
    m1_raddr_valid = 1'b1; m1_raddr = 16'h1111;
    m2_raddr_valid = 1'b0; m2_raddr = '0;
    m1_rdata_ready = 1'b1; m2_rdata_ready = 1'b1;
    s_raddr_ready = 1'b0; s_rdata_valid = 1'b1; s_rdata = 32'hFFFF_FFFF;
    // Outputs stay quiet under reset even with a live request.
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("por");
    m1_raddr_valid = 1'b0; s_rdata_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Single m1 request with a zero-wait slave.
    run_txn(2'b01, 16'h0010, 16'h0000, 2'b01, 32'hDEAD_BEEF, 0, 0, 0);
    // Single m2 request.
    run_txn(2'b10, 16'h0000, 16'h1234, 2'b10, 32'h0BAD_F00D, 0, 0, 0);

    // Tie-breaking from a fresh reset, both masters requesting every time.
    pulse_reset();
    for (int k = 0; k < 3; k++)
      run_txn(2'b11, 16'h0000, 16'h8000, tie_g[k], 32'hA000_0000 + k, 0, 0, 0);

    // Slave stalls on both phases.
    run_txn(2'b01, 16'h0ABC, 16'h0000, 2'b01, 32'h1357_9BDF, 5, 3, 0);
    // Owner m2 back-pressures read data.
    run_txn(2'b10, 16'h0000, 16'h4321, 2'b10, 32'h2468_ACE0, 0, 0, 4);
    // Mixed stalls with random data.
    run_txn(2'b01, 16'h7FFE, 16'h0000, 2'b01, $urandom, 2, 1, 2);

    // Reset while in DATA with valid data presented to a stalled owner.
    @(posedge clk); #1;
    m1_raddr_valid = 1'b1; m1_raddr = 16'h0042;
    @(negedge clk);
    chk("rstdata_grant", {m2_raddr_ready, m1_raddr_ready}, 2'b01);
    @(posedge clk); #1;
    m1_raddr_valid = 1'b0; s_raddr_ready = 1'b1;
    @(posedge clk); #1;
    s_raddr_ready = 1'b0; s_rdata_valid = 1'b1; s_rdata = 32'h55AA_55AA;
    m1_rdata_ready = 1'b0;
    #1;
    chk("rstdata_in_data", m1_rdata_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk_quiet("rstdata");
    @(posedge clk); #3;
    rst = 1'b1;
    m1_rdata_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_rdata_valid", {m2_rdata_valid, m1_rdata_valid}, 0);
      chk("post_rst_busy", busy, 0);
    end
    $display("txn reset-in-DATA abandoned addr=0042");
    @(posedge clk); #1;
    s_rdata_valid = 1'b0;

    // A new grant after that reset works normally.
    run_txn(2'b10, 16'h0000, 16'hBEEF, 2'b10, 32'hCAFE_F00D, 1, 1, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
